dice_cgra_tid_dispatch: RTL and testbench
=========================================

DICE_CGRA_TID_DISPATCH -- requirements
Module: dice_cgra_tid_dispatch

Interface
REQ-001 SHALL have parameter TOTAL_TID, default 512: number of thread IDs in the TID space.
REQ-002 SHALL have parameter TID_WIDTH, default $clog2(TOTAL_TID): width of a TID.
REQ-003 SHALL have parameter MAX_LATENCY, default 32: maximum CGRA pipe depth, used only by the perf logic.
REQ-004 SHALL have port clk, input, 1: clock, all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: launch request for a dispatch batch.
REQ-007 SHALL have port tid_base, input, TID_WIDTH: first TID of the batch, sampled on accepted start.
REQ-008 SHALL have port tid_count, input, TID_WIDTH+1: number of TIDs to issue (0..TOTAL_TID), sampled on accepted start.
REQ-009 SHALL have port stall, input, 1: issue hold from downstream.
REQ-010 SHALL have port abort, input, 1: cancel the batch and flush the pipe.
REQ-011 SHALL have port pipe_empty, input, 1: empty flag from the TID shift register.
REQ-012 SHALL have port out_tid, output, TID_WIDTH: TID toward the shift register in_tid.
REQ-013 SHALL have port out_valid, output, 1: TID valid toward the shift register in_valid.
REQ-014 SHALL have port pipe_clr, output, 1: one-cycle flush pulse toward the shift register clr.
REQ-015 SHALL have port busy, output, 1: high in the ISSUE and DRAIN states.
REQ-016 SHALL have port done, output, 1: one-cycle batch-completion pulse.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-018 IDLE: start=1 and abort=0 SHALL be an accepted start.
REQ-019 On an accepted start, the block SHALL latch cur_tid=tid_base and remaining=tid_count.
REQ-020 On an accepted start, the block SHALL pulse pipe_clr for that cycle.
REQ-021 On an accepted start, the next state SHALL be ISSUE if tid_count!=0, else DONE.
REQ-022 ISSUE: out_valid SHALL equal !stall, driven combinationally from state and stall.
REQ-023 out_tid SHALL always equal the cur_tid register.
REQ-024 ISSUE with stall=0: cur_tid SHALL advance by 1, wrapping TOTAL_TID-1 to 0.
REQ-025 ISSUE with stall=0: remaining SHALL decrement by 1.
REQ-026 ISSUE with stall=0 and remaining==1: the next state SHALL be DRAIN.
REQ-027 ISSUE with stall=1: out_valid SHALL be 0 and cur_tid and remaining SHALL hold.
REQ-028 The first out_valid SHALL occur in the cycle after the accepted start (1-cycle launch latency) when stall=0.
REQ-029 Issue throughput SHALL be one TID per unstalled cycle, with no bubbles between consecutive TIDs.
REQ-030 DRAIN: the block SHALL move to DONE in the cycle after pipe_empty is sampled 1, and remain in DRAIN while pipe_empty=0.
REQ-031 DRAIN: out_valid SHALL be 0.
REQ-032 DONE: done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-033 start in ISSUE, DRAIN or DONE SHALL be ignored, with no re-latch and no queueing.
REQ-034 abort in ISSUE, DRAIN or DONE SHALL force IDLE on the next edge.
REQ-035 abort in ISSUE, DRAIN or DONE SHALL pulse pipe_clr for 1 cycle.
REQ-036 After such an abort, no done pulse SHALL occur for the aborted batch.
REQ-037 abort SHALL take priority over start in the same cycle.
REQ-038 abort in IDLE SHALL do nothing.
REQ-039 abort during ISSUE SHALL force out_valid=0 in that same cycle.
REQ-040 tid_count>TOTAL_TID SHALL be saturated to TOTAL_TID on latch.

Reset
REQ-041 On rst_n=0, the state SHALL be IDLE.
REQ-042 On rst_n=0, cur_tid and remaining SHALL be 0.
REQ-043 On rst_n=0, out_valid, pipe_clr, busy and done SHALL be 0, and out_tid SHALL be 0.
REQ-044 Reset asserted mid-batch SHALL abandon the batch silently, with no done and no pipe_clr pulse.
REQ-045 After rst_n deasserts, the block SHALL accept start on the first clock edge.

Configuration
REQ-046 Macro DICE_TID_DISPATCH_PERF_EN SHALL control the performance counters.
REQ-047 When DICE_TID_DISPATCH_PERF_EN is defined, the block SHALL add outputs perf_issue_cyc[31:0], perf_stall_cyc[31:0] and perf_drain_cyc[31:0].
REQ-048 perf_issue_cyc SHALL count ISSUE cycles with out_valid=1.
REQ-049 perf_stall_cyc SHALL count ISSUE cycles with stall=1.
REQ-050 perf_drain_cyc SHALL count DRAIN cycles.
REQ-051 The perf counters SHALL clear on accepted start and on reset.
REQ-052 The perf counters SHALL saturate at 2^32-1 and hold after done.
REQ-053 When DICE_TID_DISPATCH_PERF_EN is undefined, the perf ports and logic SHALL be absent, with all other behaviour identical.

Verification
REQ-054 Basic: start, tid_base=0, tid_count=4, stall=0, pipe_empty rising 3 cycles after DRAIN entry -> out_tid 0,1,2,3 on cycles 1-4 with out_valid=1; done one cycle after pipe_empty is seen high; busy high in ISSUE and DRAIN only.
REQ-055 Wrap: tid_base=510, tid_count=4 -> out_tid sequence 510,511,0,1.
REQ-056 Stall: tid_count=3, stall high on the 2nd issue cycle for 2 cycles -> out_tid 0,(hold 1 with valid=0 for 2 cycles),1,2; with PERF_EN, perf_issue_cyc=3 and perf_stall_cyc=2.
REQ-057 Abort: abort during the 3rd issue cycle of tid_count=8 -> that cycle out_valid=0, pipe_clr=1, then IDLE with no done; a new start is accepted on the next cycle.
REQ-058 Zero count and ignored start: tid_count=0 -> done pulses in the cycle after start with no out_valid; start pulsed while busy -> no change to the out_tid sequence.
REQ-059 Reset mid-batch: rst_n low during ISSUE -> all outputs 0 immediately; after release, start with tid_count=2 -> normal issue.

Source files
------------

// File: rtl/dice_cgra_tid_dispatch.sv
// dice_cgra_tid_dispatch: issues a contiguous, wrapping run of thread IDs into the CGRA TID shift register.
// Define DICE_TID_DISPATCH_PERF_EN to add the issue/stall/drain performance counters.
module dice_cgra_tid_dispatch #(
    parameter int unsigned TOTAL_TID   = 512,
    parameter int unsigned TID_WIDTH   = $clog2(TOTAL_TID),
    parameter int unsigned MAX_LATENCY = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [TID_WIDTH-1:0] tid_base,
    input  logic [TID_WIDTH:0]   tid_count,
    input  logic                 stall,
    input  logic                 abort,
    input  logic                 pipe_empty,
    output logic [TID_WIDTH-1:0] out_tid,
    output logic                 out_valid,
    output logic                 pipe_clr,
    output logic                 busy,
    output logic                 done
`ifdef DICE_TID_DISPATCH_PERF_EN
    ,
    output logic [31:0]          perf_issue_cyc,
    output logic [31:0]          perf_stall_cyc,
    output logic [31:0]          perf_drain_cyc
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [TID_WIDTH:0]   CNT_MAX = (TID_WIDTH+1)'(TOTAL_TID);
    localparam logic [TID_WIDTH-1:0] TID_MAX = TID_WIDTH'(TOTAL_TID - 1);
    localparam logic [TID_WIDTH:0]   CNT_ONE = (TID_WIDTH+1)'(1);

    if (TOTAL_TID < 2 || MAX_LATENCY == 0) begin : g_cfg_check
        $error("dice_cgra_tid_dispatch: TOTAL_TID must be >= 2 and MAX_LATENCY > 0");
    end

    state_e                 state_q;
    logic [TID_WIDTH-1:0]   cur_tid_q;
    logic [TID_WIDTH:0]     remaining_q;

    logic                   start_acc;
    logic                   abort_act;
    logic [TID_WIDTH:0]     cnt_sat;
    logic [TID_WIDTH-1:0]   tid_next;

    assign start_acc = (state_q == S_IDLE) && start && !abort;
    assign abort_act = (state_q != S_IDLE) && abort;
    assign cnt_sat   = (tid_count > CNT_MAX) ? CNT_MAX : tid_count;
    assign tid_next  = (cur_tid_q == TID_MAX) ? '0 : cur_tid_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_tid_q   <= '0;
            remaining_q <= '0;
        end else if (abort_act) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        cur_tid_q   <= tid_base;
                        remaining_q <= cnt_sat;
                        state_q     <= (cnt_sat == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        cur_tid_q   <= tid_next;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == CNT_ONE) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Flush and issue qualifiers act in the cycle they are requested; rst_n gates the flush during reset.
    assign out_tid   = cur_tid_q;
    assign out_valid = (state_q == S_ISSUE) && !stall && !abort;
    assign pipe_clr  = rst_n && (start_acc || abort_act);
    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE) && !abort;

`ifdef DICE_TID_DISPATCH_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_drain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
            perf_drain_q <= '0;
        end else if (start_acc) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
            perf_drain_q <= '0;
        end else begin
            if (out_valid && (perf_issue_q != '1)) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
            if ((state_q == S_ISSUE) && stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if ((state_q == S_DRAIN) && (perf_drain_q != '1)) begin
                perf_drain_q <= perf_drain_q + 32'd1;
            end
        end
    end

    assign perf_issue_cyc = perf_issue_q;
    assign perf_stall_cyc = perf_stall_q;
    assign perf_drain_cyc = perf_drain_q;
`endif

endmodule

// File: tb/tb_dice_cgra_tid_dispatch.sv
// Scoreboard bench for dice_cgra_tid_dispatch: a batch-level driver predicts the TID stream and per-cycle flags,
// a negedge monitor pops and compares. Perf counters are checked when DICE_TID_DISPATCH_PERF_EN is defined.
module tb_dice_cgra_tid_dispatch;

    localparam int unsigned TOTAL = 512;
    localparam int unsigned TW    = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] tid_base = '0;
    logic [TW:0]   tid_count = '0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic          pipe_empty = 1'b0;
    logic [TW-1:0] out_tid;
    logic          out_valid;
    logic          pipe_clr;
    logic          busy;
    logic          done;
`ifdef DICE_TID_DISPATCH_PERF_EN
    logic [31:0]   perf_issue_cyc;
    logic [31:0]   perf_stall_cyc;
    logic [31:0]   perf_drain_cyc;
`endif

    always #5 clk = ~clk;

    dice_cgra_tid_dispatch #(
        .TOTAL_TID  (TOTAL),
        .TID_WIDTH  (TW),
        .MAX_LATENCY(32)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tid_base  (tid_base),
        .tid_count (tid_count),
        .stall     (stall),
        .abort     (abort),
        .pipe_empty(pipe_empty),
        .out_tid   (out_tid),
        .out_valid (out_valid),
        .pipe_clr  (pipe_clr),
        .busy      (busy),
        .done      (done)
`ifdef DICE_TID_DISPATCH_PERF_EN
        ,
        .perf_issue_cyc(perf_issue_cyc),
        .perf_stall_cyc(perf_stall_cyc),
        .perf_drain_cyc(perf_drain_cyc)
`endif
    );

    // Expected issue stream: TID values, -1 marks the batch's done pulse.
    int   q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   mon_t;
    logic exp_valid = 1'b0;
    logic exp_clr   = 1'b0;
    logic exp_busy  = 1'b0;
    logic exp_done  = 1'b0;
    logic exp_rst   = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic v, input logic c, input logic b, input logic d);
        exp_valid = v;
        exp_clr   = c;
        exp_busy  = b;
        exp_done  = d;
    endtask

    task automatic noise();
        start      = 1'($urandom_range(1));
        tid_base   = TW'($urandom);
        tid_count  = (TW+1)'($urandom);
        pipe_empty = 1'($urandom_range(1));
        stall      = 1'($urandom_range(1));
    endtask

    task automatic cleanup();
        q.delete();
        start = 1'b0;
        abort = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(exp_valid));
        chk("pipe_clr", int'(pipe_clr), int'(exp_clr));
        chk("busy", int'(busy), int'(exp_busy));
        chk("done", int'(done), int'(exp_done));
        if (exp_rst) begin
            chk("out_tid_reset", int'(out_tid), 0);
        end else if (exp_busy && q.size() > 0 && q[0] >= 0) begin
            chk("out_tid_hold", int'(out_tid), q[0]);
        end
        if (out_valid) begin
            chk("issue_pending", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_t = q.pop_front();
                chk("issued_tid", int'(out_tid), mon_t);
            end
        end
        if (done) begin
            chk("done_pending", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_t = q.pop_front();
                chk("done_order", mon_t, -1);
            end
        end
    end

    // abort_phase: 0 none, 1 at issue cycle abort_at, 2 on the last drain cycle, 3 in the done cycle.
    task automatic run_batch(input int base, input int count, input int stall_pct,
                             input logic [31:0] stall_mask, input int abort_phase,
                             input int abort_at, input int drain_len);
        int   cnt_sat, issued, cyc, m_issue, m_stall, m_drain;
        logic st, ab;
        cnt_sat = (count > int'(TOTAL)) ? int'(TOTAL) : count;
        m_issue = 0;
        m_stall = 0;
        m_drain = 0;
        noise();
        start     = 1'b1;
        abort     = 1'b0;
        tid_base  = TW'(base);
        tid_count = (TW+1)'(count);
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < cnt_sat; i++) q.push_back((base + i) % int'(TOTAL));
        q.push_back(-1);
        tick();

        issued = 0;
        cyc    = 0;
        while (issued < cnt_sat) begin
            st = ((cyc < 32) && stall_mask[cyc[4:0]]) || (int'($urandom_range(99)) < stall_pct);
            ab = (abort_phase == 1) && (cyc == abort_at);
            noise();
            stall = st;
            abort = ab;
            set_exp(!st && !ab, ab, 1'b1, 1'b0);
            tick();
            if (ab) begin
                cleanup();
                return;
            end
            if (st) m_stall++;
            else begin
                m_issue++;
                issued++;
            end
            cyc++;
        end

        if (cnt_sat != 0) begin
            for (int d = 0; d <= drain_len; d++) begin
                ab = (abort_phase == 2) && (d == drain_len);
                noise();
                pipe_empty = (d == drain_len);
                abort      = ab;
                set_exp(1'b0, ab, 1'b1, 1'b0);
                tick();
                m_drain++;
                if (ab) begin
                    cleanup();
                    return;
                end
            end
        end

        ab = (abort_phase == 3);
        noise();
        abort = ab;
        set_exp(1'b0, ab, 1'b0, !ab);
        tick();
        if (ab) begin
            cleanup();
            return;
        end
        start = 1'b0;
        abort = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DICE_TID_DISPATCH_PERF_EN
        if (abort_phase == 0) begin
            chk("perf_issue_cyc", int'(perf_issue_cyc), m_issue);
            chk("perf_stall_cyc", int'(perf_stall_cyc), m_stall);
            chk("perf_drain_cyc", int'(perf_drain_cyc), m_drain);
        end
`endif
    endtask

    // Idle cycles: abort alone, or abort together with start, must leave the block untouched.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            if (start) abort = 1'b1;
            else abort = 1'($urandom_range(1));
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        exp_rst = 1'b1;
        repeat (3) tick();
        rst_n   = 1'b1;
        exp_rst = 1'b0;

        run_batch(0, 4, 0, 32'h0, 0, 0, 3);
        run_batch(510, 4, 0, 32'h0, 0, 0, 1);
        run_batch(0, 3, 0, 32'h6, 0, 0, 2);
        idle_cycles(3);
        run_batch(20, 8, 0, 32'h0, 1, 2, 0);
        run_batch(7, 5, 0, 32'h0, 0, 0, 0);
        run_batch(33, 0, 0, 32'h0, 0, 0, 0);
        run_batch(100, 6, 20, 32'h0, 2, 0, 2);
        run_batch(200, 3, 0, 32'h0, 3, 0, 1);
        run_batch(300, 600, 10, 32'h0, 0, 0, 2);

        noise();
        start     = 1'b1;
        abort     = 1'b0;
        stall     = 1'b0;
        tid_base  = TW'(100);
        tid_count = (TW+1)'(10);
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) q.push_back(100 + i);
        q.push_back(-1);
        tick();
        start = 1'b0;
        set_exp(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        start   = 1'b1;
        rst_n   = 1'b0;
        exp_rst = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        q.delete();
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_tid", int'(out_tid), 0);
        chk("reset_busy", int'(busy), 0);
        tick();
        tick();
        rst_n   = 1'b1;
        exp_rst = 1'b0;
        start   = 1'b0;
        run_batch(45, 2, 0, 32'h0, 0, 0, 1);

        for (int b = 0; b < 40; b++) begin
            int cnt, ph;
            cnt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 24));
            ph  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_batch(int'($urandom_range(0, TOTAL - 1)), cnt, int'($urandom_range(0, 60)), $urandom,
                      ph, int'($urandom_range(0, cnt + 3)), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end

        idle_cycles(2);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
